// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared FSM state and owner-select encodings for the data-memory arbiter
package data_mem_arb_pkg;
  typedef enum logic {IDLE, DMA_OWN} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_CPU, SEL_DMA} sel_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU request, DMA request and data-memory port signals of the arbiter
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid, mem_re, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arb_starve_cnt.sv
// data_mem_arb_starve_cnt: saturating count of consecutive cycles the DMA waits without a grant
module data_mem_arb_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  output logic o_sat
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (reset || !i_wait) r_cnt <= '0;
    else if (r_cnt != W'(LIMIT)) r_cnt <= r_cnt + 1'b1;
  end
  assign o_sat = r_cnt == W'(LIMIT);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data-memory port between the CPU MEM stage and a bursting DMA requester
// Defining DATA_MEM_ARB_FAIR_EN forces a DMA grant after STARVE_LIMIT starved cycles.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DMA_BURST_MAX = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input logic clk,
  input logic reset,
  data_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(DMA_BURST_MAX + 1);
  state_t            r_state;
  logic [CW-1:0]     r_burst_cnt;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_dma_rdata;
  sel_t              w_sel;
  logic              w_cont, w_force, w_dma, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
`ifdef DATA_MEM_ARB_FAIR_EN
  data_mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .i_wait (bus.dma_req & ~w_dma),
    .o_sat  (w_force)
  );
`else
  assign w_force = STARVE_LIMIT < 1;
`endif
  // burst_cnt never exceeds DMA_BURST_MAX, so != is the "room left in burst" test
  always_comb begin
    w_cont  = r_state == DMA_OWN && bus.dma_req && r_burst_cnt != CW'(DMA_BURST_MAX);
    w_sel   = reset ? SEL_NONE :
              (w_cont || (bus.dma_req && (!bus.cpu_req || w_force))) ? SEL_DMA :
              bus.cpu_req ? SEL_CPU : SEL_NONE;
    w_dma   = w_sel == SEL_DMA;
    w_we    = w_dma ? bus.dma_we : bus.cpu_we;
    w_addr  = w_dma ? bus.dma_addr : bus.cpu_addr;
    w_wdata = w_dma ? bus.dma_wdata : bus.cpu_wdata;
  end
  assign bus.mem_addr   = w_addr;
  assign bus.mem_wdata  = w_wdata;
  assign bus.mem_we     = w_sel != SEL_NONE && w_we;
  assign bus.mem_re     = w_sel != SEL_NONE && !w_we;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = bus.cpu_req && w_sel != SEL_CPU && !reset;
  assign bus.dma_gnt    = w_dma;
  assign bus.dma_rdata  = r_dma_rdata;
  assign bus.dma_rvalid = r_dma_rvalid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_burst_cnt  <= '0;
      r_dma_rvalid <= 1'b0;
      r_dma_rdata  <= '0;
    end else begin
      r_state      <= w_dma ? DMA_OWN : IDLE;
      r_burst_cnt  <= !w_dma ? '0 : w_cont ? r_burst_cnt + 1'b1 : CW'(1);
      r_dma_rvalid <= w_dma && !bus.dma_we;
      if (w_dma && !bus.dma_we) r_dma_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scenarios plus random traffic checked against a behavioural arbitration model
module tb_data_mem_arbiter;
  localparam int AW = 32, DW = 32, BMAX = 4, SLIM = 8;
`ifdef DATA_MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DMA_BURST_MAX(BMAX), .STARVE_LIMIT(SLIM)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );
  // memory seen by the DUT, and the memory the model expects
  logic [DW-1:0] mem     [256] = '{default: '0};
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  // model: who owns the port follows from beats taken in the current ownership and cycles waited
  int m_beats = 0;
  int m_wait = 0;
  logic m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic exp_dma, exp_cpu;
  always_comb begin
    exp_dma = !rst && bus.dma_req &&
              ((m_beats > 0 && m_beats < BMAX) || !bus.cpu_req || (FAIR && m_wait >= SLIM));
    exp_cpu = !rst && bus.cpu_req && !exp_dma;
  end
  always @(posedge clk) begin
    if (rst) begin
      m_beats  <= 0;
      m_wait   <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
    end else begin
      m_beats  <= !exp_dma ? 0 : (m_beats > 0 && m_beats < BMAX) ? m_beats + 1 : 1;
      m_wait   <= (bus.dma_req && !exp_dma) ? ((m_wait < SLIM) ? m_wait + 1 : SLIM) : 0;
      m_rvalid <= exp_dma && !bus.dma_we;
      if (exp_dma && !bus.dma_we) m_rdata <= ref_mem[bus.dma_addr[9:2]];
      if (exp_dma && bus.dma_we) ref_mem[bus.dma_addr[9:2]] <= bus.dma_wdata;
      if (exp_cpu && bus.cpu_we) ref_mem[bus.cpu_addr[9:2]] <= bus.cpu_wdata;
    end
  end

  task automatic set_idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.dma_req = 1'b1; bus.dma_we = 1'b1;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b expected 0", bus.mem_re); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", bus.dma_gnt); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.cpu_stall); end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.dma_rdata); end
    @(negedge clk);
  endtask

  task automatic test_cpu_only();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL cpu_wr_mem_we: got %b expected 1", bus.mem_we); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %b expected 0", bus.cpu_stall); end
    @(negedge clk);
    bus.cpu_we = 1'b0;
    #1;
    checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_data: got %h expected deadbeef", bus.cpu_rdata); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall: got %b expected 0", bus.cpu_stall); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL cpu_rd_gnt: got %b expected 0", bus.dma_gnt); end
    checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL cpu_rd_mem_re: got %b expected 1", bus.mem_re); end
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      bus.cpu_we = 1'($urandom_range(0, 1));
      bus.cpu_addr = AW'($urandom_range(0, 15)) << 2;
      bus.cpu_wdata = $urandom;
      #1;
      checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rand_stall c=%0d: got %b expected 0", c, bus.cpu_stall); end
      if (!bus.cpu_we) begin
        checks++;
        if (bus.cpu_rdata !== ref_mem[bus.cpu_addr[9:2]]) begin
          errors++; $display("FAIL cpu_rand_rdata c=%0d: got %h expected %h", c, bus.cpu_rdata, ref_mem[bus.cpu_addr[9:2]]);
        end
      end
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_dma_burst();
    logic [DW-1:0] vals [6];
    int beat = 0;
    int c = 0;
    for (int i = 0; i < 6; i++) vals[i] = $urandom;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1;
    for (c = 0; c < 12 && beat < 6; c++) begin
      bus.dma_addr = 32'h100 + AW'(4 * beat);
      bus.dma_wdata = vals[beat];
      #1;
      checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL burst_gnt c=%0d: got %b expected 1", c, bus.dma_gnt); end
      if (bus.dma_gnt) beat++;
      @(negedge clk);
    end
    set_idle();
    checks++; if (beat != 6 || c != 6) begin errors++; $display("FAIL burst_beats: got %0d beats in %0d cycles expected 6 in 6", beat, c); end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem[64 + i] !== vals[i]) begin errors++; $display("FAIL burst_mem i=%0d: got %h expected %h", i, mem[64 + i], vals[i]); end
    end
  endtask

  task automatic test_contention();
    logic [5:0] cr = 6'b011100;
    logic [5:0] eg = 6'b101111;
    logic [5:0] es = 6'b001100;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h180;
    for (int c = 0; c < 6; c++) begin
      bus.cpu_req = cr[c];
      bus.dma_wdata = $urandom;
      #1;
      checks++; if (bus.dma_gnt !== eg[c]) begin errors++; $display("FAIL cont_gnt c=%0d: got %b expected %b", c, bus.dma_gnt, eg[c]); end
      checks++; if (bus.cpu_stall !== es[c]) begin errors++; $display("FAIL cont_stall c=%0d: got %b expected %b", c, bus.cpu_stall, es[c]); end
      if (bus.dma_gnt) bus.dma_addr = bus.dma_addr + 4;
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_dma_read();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h200; bus.dma_wdata = 32'h12345678;
    @(negedge clk);
    set_idle();
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h200;
    #1;
    checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b expected 1", bus.dma_gnt); end
    checks++; if (bus.mem_re !== 1'b1) begin errors++; $display("FAIL rd_mem_re: got %b expected 1", bus.mem_re); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early: got %b expected 0", bus.dma_rvalid); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (bus.dma_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b expected 1", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata: got %h expected 12345678", bus.dma_rdata); end
    @(negedge clk);
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_late: got %b expected 0", bus.dma_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    bit eg;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h40;
    for (int c = 0; c < 12; c++) begin
      eg = FAIR && c == SLIM;
      #1;
      checks++; if (bus.dma_gnt !== eg) begin errors++; $display("FAIL fair_gnt c=%0d: got %b expected %b", c, bus.dma_gnt, eg); end
      checks++; if (bus.cpu_stall !== eg) begin errors++; $display("FAIL fair_stall c=%0d: got %b expected %b", c, bus.cpu_stall, eg); end
      @(negedge clk);
      if (eg) bus.dma_req = 1'b0;
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h80;
    #1;
    checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL rmb_beat1_gnt: got %b expected 1", bus.dma_gnt); end
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.dma_addr = 32'h84;
    #1;
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rmb_rst_gnt: got %b expected 0", bus.dma_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rmb_rst_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rmb_rst_stall: got %b expected 0", bus.cpu_stall); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL rmb_rvalid: got %b expected 0", bus.dma_rvalid); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rmb_after_gnt: got %b expected 0", bus.dma_gnt); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rmb_after_stall: got %b expected 0", bus.cpu_stall); end
    @(negedge clk);
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_random_traffic();
    bit cpu_hold = 1'b0;
    bit dma_hold = 1'b0;
    logic exp_we, exp_re;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    for (int c = 0; c < 400; c++) begin
      if (!cpu_hold) begin
        bus.cpu_req = 1'($urandom_range(0, 1));
        bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = AW'($urandom_range(0, 31)) << 2;
        bus.cpu_wdata = $urandom;
      end
      if (!dma_hold) begin
        bus.dma_req = $urandom_range(0, 2) != 0;
        bus.dma_we = 1'($urandom_range(0, 1));
        bus.dma_addr = AW'($urandom_range(0, 31)) << 2;
        bus.dma_wdata = $urandom;
      end
      #1;
      exp_we = exp_dma ? bus.dma_we : (exp_cpu && bus.cpu_we);
      exp_re = exp_dma ? !bus.dma_we : (exp_cpu && !bus.cpu_we);
      exp_addr = exp_dma ? bus.dma_addr : bus.cpu_addr;
      exp_wd = exp_dma ? bus.dma_wdata : bus.cpu_wdata;
      checks++; if (bus.dma_gnt !== exp_dma) begin errors++; $display("FAIL rnd_gnt c=%0d: got %b expected %b", c, bus.dma_gnt, exp_dma); end
      checks++; if (bus.cpu_stall !== (bus.cpu_req && !exp_cpu)) begin errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, bus.cpu_stall, bus.cpu_req && !exp_cpu); end
      checks++; if (bus.mem_we !== exp_we) begin errors++; $display("FAIL rnd_mem_we c=%0d: got %b expected %b", c, bus.mem_we, exp_we); end
      checks++; if (bus.mem_re !== exp_re) begin errors++; $display("FAIL rnd_mem_re c=%0d: got %b expected %b", c, bus.mem_re, exp_re); end
      checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL rnd_mem_addr c=%0d: got %h expected %h", c, bus.mem_addr, exp_addr); end
      checks++; if (bus.mem_wdata !== exp_wd) begin errors++; $display("FAIL rnd_mem_wdata c=%0d: got %h expected %h", c, bus.mem_wdata, exp_wd); end
      checks++; if (bus.dma_rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid c=%0d: got %b expected %b", c, bus.dma_rvalid, m_rvalid); end
      if (m_rvalid) begin
        checks++; if (bus.dma_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, bus.dma_rdata, m_rdata); end
      end
      if (exp_cpu && !bus.cpu_we) begin
        checks++;
        if (bus.cpu_rdata !== ref_mem[bus.cpu_addr[9:2]]) begin
          errors++; $display("FAIL rnd_cpu_rdata c=%0d: got %h expected %h", c, bus.cpu_rdata, ref_mem[bus.cpu_addr[9:2]]);
        end
      end
      cpu_hold = bus.cpu_req && !exp_cpu;
      dma_hold = bus.dma_req && !exp_dma;
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rnd_mem i=%0d: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    set_idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_cpu_only();
    test_dma_burst();
    test_contention();
    test_dma_read();
    test_fairness();
    test_reset_mid_burst();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
